// File: rtl/zion_riscv_isa_lib_bits_de_stage_pkg.sv
// Shared constants and the decoded-entry type for the bit-op decode stage.
// Opcodes and funct3 values are the RISC-V base encodings the stage recognises.
// Operands are carried at the widest supported width; RV32 builds use the low half.
package zion_riscv_isa_lib_bits_de_stage_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_XOR = 3'b100;

    localparam logic [6:0] F7_BASE = 7'b0000000;

    // Widest CPU_WIDTH (RV64); an entry always reserves this many operand bits.
    localparam int XLEN_MAX = 64;

    typedef struct packed {
        logic                and_en;
        logic                or_en;
        logic                xor_en;
        logic                hit;
        logic [4:0]          rd;
        logic [XLEN_MAX-1:0] s1;
        logic [XLEN_MAX-1:0] s2;
    } de_entry_t;

    localparam int ENTRY_W = $bits(de_entry_t);

    // True for the three logical funct3 codes this stage decodes.
    function automatic logic is_bitop_f3(input logic [2:0] f3);
        return (f3 == F3_AND) || (f3 == F3_OR) || (f3 == F3_XOR);
    endfunction

endpackage

// File: rtl/zion_riscv_isa_lib_bits_de_stage_if.sv
// Handshake bundle between the register-read side, the decode stage and execute.
// master = the side driving instructions and out_ready; slave = the decode stage.
// CPU_WIDTH must match 32*(RV64+1) of the attached stage.
interface zion_riscv_isa_lib_bits_de_stage_if #(
    parameter int CPU_WIDTH = 32
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_inst;
    logic [CPU_WIDTH-1:0] in_rs1_data;
    logic [CPU_WIDTH-1:0] in_rs2_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_and_en;
    logic                 out_or_en;
    logic                 out_xor_en;
    logic [CPU_WIDTH-1:0] out_s1;
    logic [CPU_WIDTH-1:0] out_s2;
    logic [4:0]           out_rd;
    logic                 out_hit;

    modport master (
        output flush, in_valid, in_inst, in_rs1_data, in_rs2_data, out_ready,
        input  in_ready, out_valid, out_and_en, out_or_en, out_xor_en,
               out_s1, out_s2, out_rd, out_hit
    );

    modport slave (
        input  flush, in_valid, in_inst, in_rs1_data, in_rs2_data, out_ready,
        output in_ready, out_valid, out_and_en, out_or_en, out_xor_en,
               out_s1, out_s2, out_rd, out_hit
    );
endinterface

// File: rtl/zion_riscv_isa_lib_bits_de_skid.sv
// Purpose: generic 2-entry in-order FIFO (skid buffer) with synchronous flush.
// Latency: 1 cycle push-to-head; head data comes straight from storage flops.
// Backpressure: push ready = (count<2) from registered count, independent of pop ready.
module zion_riscv_isa_lib_bits_de_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_push_vld,
    output logic         o_push_rdy,
    input  logic [W-1:0] i_push_dat,
    output logic         o_pop_vld,
    input  logic         i_pop_rdy,
    output logic [W-1:0] o_pop_dat
);
    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign o_push_rdy = (r_count != 2'd2);
    assign o_pop_vld  = (r_count != 2'd0);
    assign o_pop_dat  = r_mem[r_rd_ptr];
    assign w_push     = i_push_vld & o_push_rdy;
    assign w_pop      = o_pop_vld & i_pop_rdy;

    // Occupancy and pointers; flush empties the buffer and wins over push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Entry storage; cleared on reset so the head reads as all-zero afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

endmodule

// File: rtl/zion_riscv_isa_lib_bits_de_stage.sv
// Purpose: decode AND/OR/XOR (OP and OP-IMM) into operands + op select; optional
//          LUI-as-OR when ZION_RISCV_ISA_LIB_BITS_DE_LUI_EN is defined.
// Latency: 1 cycle through a 2-entry skid FIFO; in_ready = (count<2), ignores out_ready.
module zion_riscv_isa_lib_bits_de_stage
    import zion_riscv_isa_lib_bits_de_stage_pkg::*;
#(
    parameter int RV64 = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    zion_riscv_isa_lib_bits_de_stage_if.slave  bus
);
    localparam int CPU_WIDTH = 32 * (RV64 + 1);

    logic [6:0]          w_opcode;
    logic [2:0]          w_funct3;
    logic [6:0]          w_funct7;
    logic [XLEN_MAX-1:0] w_rs1_ext;
    logic [XLEN_MAX-1:0] w_rs2_ext;
    logic [XLEN_MAX-1:0] w_imm_i;
    de_entry_t           w_entry;
    de_entry_t           w_head;
    logic [ENTRY_W-1:0]  w_head_dat;

    assign w_opcode  = bus.in_inst[6:0];
    assign w_funct3  = bus.in_inst[14:12];
    assign w_funct7  = bus.in_inst[31:25];
    assign w_rs1_ext = XLEN_MAX'(bus.in_rs1_data);
    assign w_rs2_ext = XLEN_MAX'(bus.in_rs2_data);
    assign w_imm_i   = {{(XLEN_MAX-12){bus.in_inst[31]}}, bus.in_inst[31:20]};

`ifdef ZION_RISCV_ISA_LIB_BITS_DE_LUI_EN
    logic [XLEN_MAX-1:0] w_imm_u;
    assign w_imm_u = {{(XLEN_MAX-32){bus.in_inst[31]}}, bus.in_inst[31:12], 12'b0};
`else
    // rs1 index bits only feed the LUI immediate.
    logic w_unused_rs1_idx;
    assign w_unused_rs1_idx = ^bus.in_inst[19:15];
`endif

    // Decode the offered instruction; unsupported encodings keep rd and zero everything else.
    always_comb begin
        w_entry    = '0;
        w_entry.rd = bus.in_inst[11:7];
        if (is_bitop_f3(w_funct3) &&
            ((w_opcode == OPC_OP_IMM) || ((w_opcode == OPC_OP) && (w_funct7 == F7_BASE)))) begin
            w_entry.hit    = 1'b1;
            w_entry.and_en = (w_funct3 == F3_AND);
            w_entry.or_en  = (w_funct3 == F3_OR);
            w_entry.xor_en = (w_funct3 == F3_XOR);
            w_entry.s1     = w_rs1_ext;
            w_entry.s2     = (w_opcode == OPC_OP) ? w_rs2_ext : w_imm_i;
        end
`ifdef ZION_RISCV_ISA_LIB_BITS_DE_LUI_EN
        else if (w_opcode == OPC_LUI) begin
            w_entry.hit   = 1'b1;
            w_entry.or_en = 1'b1;
            w_entry.s2    = w_imm_u;
        end
`endif
    end

    zion_riscv_isa_lib_bits_de_skid #(
        .W (ENTRY_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (bus.flush),
        .i_push_vld (bus.in_valid),
        .o_push_rdy (bus.in_ready),
        .i_push_dat (w_entry),
        .o_pop_vld  (bus.out_valid),
        .i_pop_rdy  (bus.out_ready),
        .o_pop_dat  (w_head_dat)
    );

    assign w_head         = de_entry_t'(w_head_dat);
    assign bus.out_and_en = w_head.and_en;
    assign bus.out_or_en  = w_head.or_en;
    assign bus.out_xor_en = w_head.xor_en;
    assign bus.out_hit    = w_head.hit;
    assign bus.out_rd     = w_head.rd;
    assign bus.out_s1     = w_head.s1[CPU_WIDTH-1:0];
    assign bus.out_s2     = w_head.s2[CPU_WIDTH-1:0];

    if (CPU_WIDTH < XLEN_MAX) begin : g_narrow
        // Upper operand halves are never driven out in an RV32 build.
        logic w_unused_hi;
        assign w_unused_hi = ^{w_head.s1[XLEN_MAX-1:CPU_WIDTH], w_head.s2[XLEN_MAX-1:CPU_WIDTH]};
    end

    // A visible entry may select at most one logical operation.
    a_onehot_en: assert property (@(posedge clk) disable iff (rst)
        bus.out_valid |-> $onehot0({bus.out_and_en, bus.out_or_en, bus.out_xor_en}));

endmodule

// File: doc/zion_riscv_isa_lib_bits_de_stage.md
ZION_RISCV_ISA_LIB_BITS_DE_STAGE -- requirements
Module: zion_riscv_isa_lib_bits_de_stage

Interface
REQ-001 Parameter RV64, default 0; 1 selects 64-bit operands, 0 selects 32-bit operands; CPU_WIDTH = 32*(RV64+1).
REQ-002 The block SHALL have one clock, clk, and an asynchronous, active-high reset, rst.
REQ-003 clk  input  1  sole clock; every flop rises on it.
REQ-004 rst  input  1  asynchronous reset, active-high.
REQ-005 flush  input  1  discards every buffered entry.
REQ-006 in_valid  input  1  instruction offered.
REQ-007 in_ready  output  1  stage can accept; acceptance = in_valid & in_ready.
REQ-008 in_inst  input  32  RISC-V instruction word.
REQ-009 in_rs1_data / in_rs2_data  input  CPU_WIDTH  register-file read data, valid with in_valid.
REQ-010 out_valid  output  1  decoded entry present.
REQ-011 out_ready  input  1  execute side consumes; transfer = out_valid & out_ready.
REQ-012 out_and_en / out_or_en / out_xor_en  output  1 each  operation select toward the bit-op execute interface (De side).
REQ-013 out_s1 / out_s2  output  CPU_WIDTH  operands.
REQ-014 out_rd  output  5  destination register, inst[11:7].
REQ-015 out_hit  output  1  entry is a supported bit-op instruction.

Function
REQ-016 Decode SHALL cover OP (0110011, funct7=0000000) and OP-IMM (0010011) with funct3 100=XOR, 110=OR, 111=AND.
REQ-017 OP: s1=rs1_data, s2=rs2_data; OP-IMM: s1=rs1_data, s2=sign-extend(inst[31:20]) to CPU_WIDTH.
REQ-018 At most one of and/or/xor_en SHALL be 1 in any entry; all three SHALL be 0 when out_hit=0.
REQ-019 Any other encoding SHALL be accepted, and SHALL produce out_hit=0, enables 0, s1=s2=0, and rd passed through.
REQ-020 Decoded entries SHALL enter a 2-entry in-order FIFO (skid buffer); outputs are driven from the head entry only and are registered (no combinational path from in_* to out_*).
REQ-021 Latency SHALL be 1 cycle: an entry accepted at edge N is visible with out_valid=1 after edge N.
REQ-022 in_ready SHALL equal (count<2), taken from registered count only and independent of out_ready.
REQ-023 A push and a pop in the same cycle SHALL leave count unchanged and preserve order; sustained throughput is 1 per cycle while out_ready=1.
REQ-024 Head outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 flush SHALL set count to 0 at the next edge and override a same-cycle push or pop; the entry offered in that cycle is dropped.
REQ-026 In simulation, an assertion SHALL flag any cycle where out_valid=1 and more than one enable is set.

Reset
REQ-027 On rst: count=0, out_valid=0, in_ready=1 (count=0), enables 0, out_hit 0, out_s1/out_s2/out_rd 0.
REQ-028 rst asserted mid-transfer SHALL discard all entries immediately, without waiting for a clock edge.

Configuration
REQ-029 Macro ZION_RISCV_ISA_LIB_BITS_DE_LUI_EN defined: LUI (0110111) SHALL decode as out_hit=1, or_en=1, s1=0, s2=sign-extend({inst[31:12],12'b0}).
REQ-030 Macro undefined: LUI SHALL be treated as an unsupported encoding (REQ-019).

Structure
REQ-031 The shared package SHALL hold the opcode constants (OP, OP_IMM, LUI), the funct3 constants (AND, OR, XOR), and a packed entry typedef {and_en, or_en, xor_en, hit, rd, s1, s2} parameterised by CPU_WIDTH.
REQ-032 The FIFO SHALL be a sub-module, zion_riscv_isa_lib_bits_de_skid; decode logic stays combinational in the top level.

Verification
REQ-033 Reset then XORI x5,x1,-1 with rs1=0x0000_00F0, RV64=0 -> one cycle later: xor_en=1, s1=0x0000_00F0, s2=0xFFFF_FFFF, rd=5, hit=1.
REQ-034 out_ready=0, three back-to-back valid ANDs -> in_ready falls after 2 accepted; raise out_ready -> all three emerge in order with no loss.
REQ-035 Streaming OR/AND/XOR with out_ready=1 -> one output per cycle; enables are one-hot every cycle.
REQ-036 SUB encoding (funct7=0100000, funct3=000) -> hit=0, enables 0, s1=s2=0.
REQ-037 LUI imm=0x80000 with RV64=1 -> with the macro: or_en=1, s2=0xFFFF_FFFF_8000_0000; without the macro: hit=0.
REQ-038 Two entries buffered, then flush together with in_valid=1 -> out_valid=0 next cycle and count=0; async rst with an entry buffered -> out_valid drops immediately.
